fdct2d_quant: RTL and testbench

- Forward counterpart of the team's idct2d: the encoder-side 8x8 forward DCT plus quantizer for the MPEG2 path.
- Host loads a 64-pixel block through a write port, then pulses en.
- Block runs a row-column fixed-point FDCT with a single time-shared multiply-accumulate unit (MAC), then quantizes each coefficient using a reciprocal quantizer matrix read via maddr/mq.
- Emits 64 saturated signed 8-bit levels on a write port (waddr/wdata/wwren) to the downstream run-length/VLC stage.

---
 rtl/fdct2d_quant.sv | 198 +++++++++++++++++++
 tb/tb_fdct2d_quant.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fdct2d_quant.sv
// fdct2d_quant: 8x8 forward DCT (row pass, then column pass, sharing one MAC)
// followed by a reciprocal-multiply quantizer producing saturated 8-bit levels.
// Optional macro FDCT_ZIGZAG_EN: emit levels in MPEG2 zigzag scan order
// (waddr = scan position, maddr = raster index) instead of raster order.
module fdct2d_quant #(
    parameter int CW = 15,
    parameter int IW = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic        rdy,
    input  logic [5:0]  iaddr,
    input  logic [7:0]  idata,
    input  logic        iwren,
    output logic [5:0]  maddr,
    input  logic [15:0] mq,
    output logic [5:0]  waddr,
    output logic [7:0]  wdata,
    output logic        wwren
);
    localparam int PW = CW + IW;   // full product width
    localparam int AW = PW + 3;    // eight-term accumulator
    localparam int QW = IW + 17;   // F times zero-extended mq

    typedef enum logic [1:0] {IDLE, ROW, COL, QUANT} state_t;

    state_t        state, state_n;
    logic [3:0]    ph;             // 0..7 MAC over x (or y), 8 = store
    logic [5:0]    pr;             // ROW {y,u}, COL {u,v}, QUANT output index
    logic          last_pair;

    logic [7:0]    ibuf [64];
    logic [IW-1:0] tbuf [64];      // R[y][u], raster 8y+u
    logic [IW-1:0] fbuf [64];      // F[v][u], raster 8v+u

    logic [2:0]           j;
    logic [7:0]           pix;
    logic [8:0]           s9;
    logic [IW-1:0]        dsel;
    logic [CW-1:0]        coef;
    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] pext, acc;
    logic [AW-1:0]        amag, aq;
    logic [IW-1:0]        stv;

    logic                 issue;
    logic [5:0]           qidx;
    logic [IW-1:0]        fq;
    logic signed [QW-1:0] qp;
    logic [QW-1:0]        qmag, qq;
    logic [7:0]           lvl;

    // Basis B(f,t) in Q14: angle (2t+1)f mod 32 folded onto one quadrant.
    function automatic logic [CW-1:0] basis(input logic [2:0] f, input logic [2:0] t);
        logic [4:0]    ang;
        logic [2:0]    k;
        logic [CW-1:0] mag;
        ang = {1'b0, t, 1'b1} * {2'b00, f};
        k   = ang[3] ? 3'd0 - ang[2:0] : ang[2:0];
        case (k)
            3'd0:    mag = CW'(5793);
            3'd1:    mag = CW'(8035);
            3'd2:    mag = CW'(7568);
            3'd3:    mag = CW'(6811);
            3'd4:    mag = CW'(5793);
            3'd5:    mag = CW'(4551);
            3'd6:    mag = CW'(3135);
            default: mag = CW'(1598);
        endcase
        return (ang[4] ^ ang[3]) ? CW'(0) - mag : mag;
    endfunction

`ifdef FDCT_ZIGZAG_EN
    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };
    assign maddr = ZZ[qidx];
`else
    assign maddr = qidx;
`endif

    assign last_pair = (ph == 4'd8) && (pr == 6'd63);
    assign rdy       = (state == IDLE);
    assign j         = ph[2:0];

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state: fixed-length phases, en only honoured when idle
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (en) state_n = ROW;
            ROW:     if (last_pair) state_n = COL;
            COL:     if (last_pair) state_n = QUANT;
            QUANT:   if (pr == 6'd63) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Phase/pair counters; pr wraps to 0 at each pass boundary
    always_ff @(posedge clk) begin
        if (reset || state == IDLE) begin
            ph <= 4'd0;
            pr <= 6'd0;
        end else if (state == QUANT) begin
            pr <= pr + 6'd1;
        end else if (ph == 4'd8) begin
            ph <= 4'd0;
            pr <= pr + 6'd1;
        end else begin
            ph <= ph + 4'd1;
        end
    end

    // MAC operands: frequency index is pr[2:0] in both passes
    always_comb begin
        pix = ibuf[{pr[5:3], j}];
        s9  = {1'b0, pix} - 9'd128;
        if (state == COL) dsel = tbuf[{j, pr[5:3]}];
        else              dsel = {{(IW-9){s9[8]}}, s9};
        coef = basis(pr[2:0], j);
        prod = $signed({{IW{coef[CW-1]}}, coef}) * $signed({{CW{dsel[IW-1]}}, dsel});
        pext = {{(AW-PW){prod[PW-1]}}, prod};
    end

    // Accumulate eight products; first term reloads
    always_ff @(posedge clk) begin
        if (reset)
            acc <= '0;
        else if ((state == ROW || state == COL) && !ph[3])
            acc <= (j == 3'd0) ? pext : acc + pext;
    end

    // Q14 -> integer, round half away from zero, saturate to IW bits
    always_comb begin
        amag = acc[AW-1] ? AW'(0) - acc : acc;
        aq   = (amag + AW'(8192)) >> 14;
        if (!acc[AW-1])
            stv = (aq > AW'(2**(IW-1) - 1)) ? {1'b0, {(IW-1){1'b1}}} : aq[IW-1:0];
        else
            stv = (aq > AW'(2**(IW-1))) ? {1'b1, {(IW-1){1'b0}}} : IW'(0) - aq[IW-1:0];
    end

    // Pixel load, accepted only while idle
    always_ff @(posedge clk) begin
        if (!reset && state == IDLE && iwren) ibuf[iaddr] <= idata;
    end

    // Pass results: R into the transpose buffer, F into the coefficient buffer
    always_ff @(posedge clk) begin
        if (ph == 4'd8) begin
            if (state == ROW) tbuf[pr] <= stv;
            if (state == COL) fbuf[{pr[2:0], pr[5:3]}] <= stv;
        end
    end

    // Quant issue runs one cycle ahead of the registered write so the write
    // strobe lines up with the QUANT state; index 0 issues on the last COL cycle.
    assign issue = (state == COL && last_pair) || (state == QUANT && pr != 6'd63);
    assign qidx  = (state == QUANT) ? pr + 6'd1 : 6'd0;

    // Level = round(F * mq / 2^16), half away from zero, saturated to int8
    always_comb begin
        fq   = fbuf[maddr];
        qp   = $signed({{(QW-IW){fq[IW-1]}}, fq}) * $signed({{(QW-16){1'b0}}, mq});
        qmag = qp[QW-1] ? QW'(0) - qp : qp;
        qq   = (qmag + QW'(32768)) >> 16;
        if (!qp[QW-1]) lvl = (qq > QW'(127)) ? 8'd127 : qq[7:0];
        else           lvl = (qq > QW'(128)) ? 8'h80 : 8'd0 - qq[7:0];
    end

    // Registered output write port
    always_ff @(posedge clk) begin
        if (reset) begin
            wwren <= 1'b0;
            waddr <= 6'd0;
            wdata <= 8'd0;
        end else begin
            wwren <= issue;
            if (issue) begin
                waddr <= qidx;
                wdata <= lvl;
            end
        end
    end
endmodule

// File: tb/tb_fdct2d_quant.sv
// Bench for fdct2d_quant: randomized blocks against a floating-point-derived
// DCT/quantizer reference, plus timing and busy-time behaviour.
module tb_fdct2d_quant;
    logic       clk = 1'b0;
    logic       reset, en, iwren, rdy, wwren;
    logic [5:0] iaddr, maddr, waddr;
    logic [7:0] idata, wdata;
    logic [15:0] mq;

    fdct2d_quant dut (
        .clk(clk), .reset(reset), .en(en), .rdy(rdy),
        .iaddr(iaddr), .idata(idata), .iwren(iwren),
        .maddr(maddr), .mq(mq),
        .waddr(waddr), .wdata(wdata), .wwren(wwren)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int pix [64];
    int qm  [64];
    int bas [8][8];
    int zz  [64];
    logic [7:0] expv [64];
    logic [7:0] obs  [64];
    int wcnt, first_c, last_c, rdy_c, order_err, maddr_err;

    assign mq = 16'(qm[maddr]);

    function automatic int basis_ref(int u, int x);
        real c = (u == 0) ? 1.0 / $sqrt(2.0) : 1.0;
        real v = 0.5 * c * $cos((2 * x + 1) * u * 3.141592653589793 / 16.0) * 16384.0;
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    endfunction

    function automatic longint rdiv(longint v, int sh);
        longint h = longint'(1) << (sh - 1);
        return (v >= 0) ? ((v + h) >>> sh) : -((-v + h) >>> sh);
    endfunction

    function automatic longint sat(longint v, longint lo, longint hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    task automatic build_tables();
        int p = 0;
        for (int u = 0; u < 8; u++)
            for (int x = 0; x < 8; x++) bas[u][x] = basis_ref(u, x);
`ifdef FDCT_ZIGZAG_EN
        for (int s = 0; s < 15; s++)
            for (int i = 0; i < 8; i++) begin
                int r = (s % 2 == 0) ? 7 - i : i;
                int c = s - r;
                if (r >= 0 && r < 8 && c >= 0 && c < 8) begin zz[p] = 8 * r + c; p++; end
            end
`else
        for (p = 0; p < 64; p++) zz[p] = p;
`endif
    endtask

    // Expected levels in emission order
    task automatic model();
        longint r [8][8];
        longint f [8][8];
        longint acc;
        for (int y = 0; y < 8; y++)
            for (int u = 0; u < 8; u++) begin
                acc = 0;
                for (int x = 0; x < 8; x++) acc += bas[u][x] * (pix[8*y+x] - 128);
                r[y][u] = sat(rdiv(acc, 14), -2048, 2047);
            end
        for (int v = 0; v < 8; v++)
            for (int u = 0; u < 8; u++) begin
                acc = 0;
                for (int y = 0; y < 8; y++) acc += bas[v][y] * r[y][u];
                f[v][u] = sat(rdiv(acc, 14), -2048, 2047);
            end
        for (int p = 0; p < 64; p++) begin
            int idx = zz[p];
            expv[p] = 8'(sat(rdiv(f[idx/8][idx%8] * qm[idx], 16), -128, 127));
        end
    endtask

    task automatic load_block();
        for (int i = 0; i < 64; i++) begin
            @(negedge clk); iwren = 1'b1; iaddr = 6'(i); idata = 8'(pix[i]);
        end
        @(negedge clk); iwren = 1'b0;
    endtask

    // mode 0 plain, 1 iwren storm while busy, 2 en pulses while busy, 3 reset at cycle 300
    task automatic run_encode(input int mode);
        wcnt = 0; first_c = 0; last_c = 0; rdy_c = 0; order_err = 0; maddr_err = 0;
        for (int i = 0; i < 64; i++) obs[i] = 8'hxx;
        @(negedge clk); en = 1'b1;
        for (int n = 1; n <= 1240; n++) begin
            @(negedge clk);
            if (wwren === 1'b1) begin
                if (wcnt == 0) first_c = n;
                last_c = n;
                if (waddr !== 6'(wcnt)) order_err++;
                obs[waddr] = wdata;
                wcnt++;
            end
            if (n >= 1152 && n <= 1215 && maddr !== 6'(zz[n-1152])) maddr_err++;
            if (rdy === 1'b1 && rdy_c == 0) rdy_c = n;
            en = 1'b0; iwren = 1'b0; reset = 1'b0;
            if (mode == 1 && n >= 100 && n < 164) begin
                iwren = 1'b1; iaddr = 6'(n - 100); idata = 8'hFF;
            end
            if (mode == 2 && (n == 10 || n == 600 || n == 1160)) en = 1'b1;
            if (mode == 3 && n == 300) reset = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b0; iwren = 1'b0; iaddr = '0; idata = '0;
        for (int i = 0; i < 64; i++) qm[i] = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checks++; if (rdy !== 1'b1)   begin errors++; $display("FAIL reset_rdy got %b want 1", rdy); end
        checks++; if (wwren !== 1'b0) begin errors++; $display("FAIL reset_wwren got %b want 0", wwren); end
        checks++; if (waddr !== 6'd0) begin errors++; $display("FAIL reset_waddr got %0d want 0", waddr); end
        checks++; if (wdata !== 8'd0) begin errors++; $display("FAIL reset_wdata got %0d want 0", wdata); end
        checks++; if (maddr !== 6'd0) begin errors++; $display("FAIL reset_maddr got %0d want 0", maddr); end
    endtask

    task automatic test_flat();
        for (int i = 0; i < 64; i++) begin pix[i] = 128; qm[i] = 'h1000; end
        model(); load_block(); run_encode(0);
        checks++; if (wcnt != 64)      begin errors++; $display("FAIL flat_count got %0d want 64", wcnt); end
        checks++; if (first_c != 1153) begin errors++; $display("FAIL flat_first got %0d want 1153", first_c); end
        checks++; if (last_c != 1216)  begin errors++; $display("FAIL flat_last got %0d want 1216", last_c); end
        checks++; if (rdy_c != 1217)   begin errors++; $display("FAIL flat_rdy got %0d want 1217", rdy_c); end
        checks++; if (order_err != 0)  begin errors++; $display("FAIL flat_order got %0d bad want 0", order_err); end
        checks++; if (maddr_err != 0)  begin errors++; $display("FAIL flat_maddr got %0d bad want 0", maddr_err); end
        for (int p = 0; p < 64; p++) begin
            checks++;
            if (obs[p] !== 8'd0) begin errors++; $display("FAIL flat_level pos %0d got %0d want 0", p, $signed(obs[p])); end
        end
    endtask

    task automatic test_black();
        for (int i = 0; i < 64; i++) begin pix[i] = 0; qm[i] = 'h1000; end
        model(); load_block();
        for (int rep = 0; rep < 2; rep++) begin
            run_encode(0);
            checks++; if (obs[0] !== 8'hC0) begin errors++; $display("FAIL black_dc rep %0d got %0d want -64", rep, $signed(obs[0])); end
            for (int p = 1; p < 64; p++) begin
                checks++;
                if (obs[p] !== expv[p] || expv[p] !== 8'd0) begin
                    errors++; $display("FAIL black_ac rep %0d pos %0d got %0d want 0", rep, p, $signed(obs[p]));
                end
            end
        end
    endtask

    task automatic test_white();
        for (int i = 0; i < 64; i++) begin pix[i] = 255; qm[i] = 'hFFFF; end
        model(); load_block(); run_encode(0);
        checks++; if (obs[0] !== 8'd127) begin errors++; $display("FAIL white_sat got %0d want 127", $signed(obs[0])); end
        for (int p = 1; p < 64; p++) begin
            checks++; if (obs[p] !== expv[p]) begin errors++; $display("FAIL white_ac pos %0d got %0d want %0d", p, $signed(obs[p]), $signed(expv[p])); end
        end
        qm[0] = 0;
        run_encode(0);
        checks++; if (obs[zz[0]] !== 8'd0) begin errors++; $display("FAIL white_mq0 got %0d want 0", $signed(obs[0])); end
    endtask

    task automatic test_random();
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 64; i++) begin
                case (b)
                    0: pix[i] = $urandom_range(0, 255);
                    1: pix[i] = (i % 8) * 30 + (i / 8) * 4 + $urandom_range(0, 3);
                    2: pix[i] = (i == 0) ? 255 : 128;
                    default: pix[i] = $urandom_range(100, 160);
                endcase
                qm[i] = (b == 3) ? $urandom_range(0, 'hFFFF) : $urandom_range(0, 'h1000);
            end
            model(); load_block(); run_encode(0);
            checks++; if (maddr_err != 0) begin errors++; $display("FAIL rand_maddr blk %0d got %0d bad want 0", b, maddr_err); end
            for (int p = 0; p < 64; p++) begin
                checks++;
                if (obs[p] !== expv[p]) begin errors++; $display("FAIL rand_level blk %0d pos %0d got %0d want %0d", b, p, $signed(obs[p]), $signed(expv[p])); end
            end
        end
    endtask

    task automatic test_busy_iwren();
        for (int i = 0; i < 64; i++) begin pix[i] = $urandom_range(0, 255); qm[i] = $urandom_range(256, 'h2000); end
        model(); load_block();
        for (int rep = 0; rep < 2; rep++) begin
            run_encode(rep == 0 ? 1 : 0);
            for (int p = 0; p < 64; p++) begin
                checks++;
                if (obs[p] !== expv[p]) begin errors++; $display("FAIL busy_iwren rep %0d pos %0d got %0d want %0d", rep, p, $signed(obs[p]), $signed(expv[p])); end
            end
        end
    endtask

    task automatic test_busy_en();
        run_encode(2);
        checks++; if (wcnt != 64)      begin errors++; $display("FAIL busy_en_count got %0d want 64", wcnt); end
        checks++; if (first_c != 1153) begin errors++; $display("FAIL busy_en_first got %0d want 1153", first_c); end
        checks++; if (rdy_c != 1217)   begin errors++; $display("FAIL busy_en_rdy got %0d want 1217", rdy_c); end
        for (int p = 0; p < 64; p++) begin
            checks++;
            if (obs[p] !== expv[p]) begin errors++; $display("FAIL busy_en_level pos %0d got %0d want %0d", p, $signed(obs[p]), $signed(expv[p])); end
        end
    endtask

    task automatic test_reset_mid();
        run_encode(3);
        checks++; if (rdy_c != 301) begin errors++; $display("FAIL midreset_rdy got %0d want 301", rdy_c); end
        checks++; if (wcnt != 0)    begin errors++; $display("FAIL midreset_writes got %0d want 0", wcnt); end
        run_encode(0);
        for (int p = 0; p < 64; p++) begin
            checks++;
            if (obs[p] !== expv[p]) begin errors++; $display("FAIL midreset_retain pos %0d got %0d want %0d", p, $signed(obs[p]), $signed(expv[p])); end
        end
    endtask

    initial begin
        build_tables();
        test_reset();
        test_flat();
        test_black();
        test_white();
        test_random();
        test_busy_iwren();
        test_busy_en();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
